// File: rtl/data_compare4.sv
`default_nettype none
// ============================================================================
// Module   : data_compare4
// Brief    : Registered unsigned magnitude comparator slice with 74x85-style
//            cascade input. Result on oData is one-hot {A>B, A<B, A=B}.
//            Optional macro DATA_COMPARE_INREG_EN adds an input register
//            stage ahead of the compare (latency 2 instead of 1).
// Revision : 1.0 - initial release
// ============================================================================
module data_compare4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iData,
  output logic [2:0]       oData
);

  // One-hot result codes, same bit mapping as the cascade input.
  localparam logic [2:0] C_GT = 3'b100;
  localparam logic [2:0] C_LT = 3'b010;
  localparam logic [2:0] C_EQ = 3'b001;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [2:0]       w_casc;
  logic [2:0]       w_result;
  logic [2:0]       r_out;

`ifdef DATA_COMPARE_INREG_EN
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_casc;

  // Input register stage; reset loads an "equal" compare so the first
  // post-reset output is a clean 3'b001 rather than stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_casc <= C_EQ;
    end else begin
      r_a    <= iData_a;
      r_b    <= iData_b;
      r_casc <= iData;
    end
  end

  assign w_a    = r_a;
  assign w_b    = r_b;
  assign w_casc = r_casc;
`else
  assign w_a    = iData_a;
  assign w_b    = iData_b;
  assign w_casc = iData;
`endif

  // Magnitude compare; on equality resolve the cascade with eq > gt > lt
  // priority, and treat an all-zero cascade as equal.
  always_comb begin
    w_result = C_EQ;
    if (w_a > w_b) begin
      w_result = C_GT;
    end else if (w_a < w_b) begin
      w_result = C_LT;
    end else if (w_casc[0] || (w_casc == 3'b000)) begin
      w_result = C_EQ;
    end else if (w_casc[2]) begin
      w_result = C_GT;
    end else begin
      w_result = C_LT;
    end
  end

  // Output register; 3'b000 is only ever seen as the reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= 3'b000;
    end else begin
      r_out <= w_result;
    end
  end

  assign oData = r_out;

endmodule
`default_nettype wire

// File: tb/tb_data_compare4.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_compare4
// Brief    : Self-checking bench for data_compare4 (single slice plus a
//            two-slice 8-bit chain) against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_compare4;

  localparam int W = 4;
`ifdef DATA_COMPARE_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [2:0]   c   = 3'b000;
  logic [2:0]   o;

  // Two-slice chain forming an 8-bit comparator.
  logic [W-1:0] al = '0, bl = '0, ah = '0, bh = '0;
  logic [2:0]   cl = 3'b001;
  logic [2:0]   o_lo, o_hi;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model history: inputs and reset seen at the previous edge.
  logic [W-1:0] p_a = '0, p_b = '0;
  logic [2:0]   p_c = 3'b000;
  logic         p_r = 1'b1;

  always #5 clk = ~clk;

  data_compare4 #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .iData_a(a), .iData_b(b), .iData(c), .oData(o)
  );

  data_compare4 #(.WIDTH(W)) u_lo (
    .clk(clk), .rst(rst), .iData_a(al), .iData_b(bl), .iData(cl), .oData(o_lo)
  );

  data_compare4 #(.WIDTH(W)) u_hi (
    .clk(clk), .rst(rst), .iData_a(ah), .iData_b(bh), .iData(o_lo), .oData(o_hi)
  );

  // Behavioural compare from the operation table.
  function automatic logic [2:0] ref_cmp(input int ua, input int ub, input logic [2:0] casc);
    if (ua > ub) return 3'b100;
    if (ua < ub) return 3'b010;
    if (casc[0] == 1'b1 || casc == 3'b000) return 3'b001;
    if (casc[2] == 1'b1) return 3'b100;
    return 3'b010;
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Apply one vector for one edge, then compare oData with the model.
  task automatic step(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [2:0] vc, input logic vr);
    logic [2:0] exp;
    a = va; b = vb; c = vc; rst = vr;
    @(posedge clk);
    #1;
    if (vr) exp = 3'b000;
    else if (LAT == 1) exp = ref_cmp(int'(va), int'(vb), vc);
    else if (p_r) exp = 3'b001;
    else exp = ref_cmp(int'(p_a), int'(p_b), p_c);
    check(tag, o, exp);
    p_a = va; p_b = vb; p_c = vc; p_r = vr;
  endtask

  initial begin
    #1;
    // Reset for two edges with arbitrary inputs.
    step("reset0", 4'hA, 4'h3, 3'b110, 1'b1);
    step("reset1", 4'h2, 4'h9, 3'b011, 1'b1);

    // Directed vectors (for LAT=2 the first one after reset yields 3'b001).
    step("gt_c000",   4'b1111, 4'b0000, 3'b000, 1'b0);
    step("gt_c010",   4'b1111, 4'b0000, 3'b010, 1'b0);
    step("lt_c000",   4'b0000, 4'b1111, 3'b000, 1'b0);
    step("lt_msb",    4'b0111, 4'b1000, 3'b000, 1'b0);
    step("eq_c100",   4'b1100, 4'b1100, 3'b100, 1'b0);
    step("eq_c010",   4'b1100, 4'b1100, 3'b010, 1'b0);
    step("eq_c001",   4'b1100, 4'b1100, 3'b001, 1'b0);
    step("eq_c000",   4'b1100, 4'b1100, 3'b000, 1'b0);
    step("eq_c111",   4'b1100, 4'b1100, 3'b111, 1'b0);
    step("eq_c110",   4'b1100, 4'b1100, 3'b110, 1'b0);
    step("flush",     4'b0001, 4'b0000, 3'b000, 1'b0);

    // Mid-stream reset and refill.
    step("mid_rst",   4'b1111, 4'b0000, 3'b010, 1'b1);
    step("refill0",   4'b0000, 4'b1111, 3'b100, 1'b0);
    step("refill1",   4'b1000, 4'b0111, 3'b010, 1'b0);

    // Random back-to-back vectors with occasional reset.
    for (int i = 0; i < 300; i++) begin
      step("random", W'($urandom), W'($urandom), 3'($urandom),
           ($urandom_range(0, 31) == 0));
    end

    // Exhaustive operand pairs x cascade codes, back to back.
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 8; j++) begin
        step("exhaustive", W'(i >> 4), W'(i), 3'(j), 1'b0);
      end
    end

    // Two-slice 8-bit chain: hold each random pair until both stages settle.
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int x, y;
      logic [7:0] vx, vy;
      logic [2:0] exp8;
      x = int'($urandom_range(0, 255));
      y = (i % 4 == 0) ? x : int'($urandom_range(0, 255));
      if (i % 8 == 1) y = x ^ 1;
      vx = 8'(x); vy = 8'(y);
      al = vx[3:0]; bl = vy[3:0]; ah = vx[7:4]; bh = vy[7:4];
      cl = (i % 2 == 0) ? 3'b001 : 3'b000;
      repeat (2 * LAT + 1) @(posedge clk);
      #1;
      exp8 = (x > y) ? 3'b100 : ((x < y) ? 3'b010 : 3'b001);
      check("chain8", o_hi, exp8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_compare4.md
# data_compare4

Registered magnitude comparator for two unsigned WIDTH-bit operands with 74x85-style cascade inputs, so that several slices can be chained to compare wider words. Each clock edge it samples the operands and the cascade input and presents a one-hot greater/less/equal result on a registered output. Standalone arithmetic helper used in the lab datapath. It also serves as the least-significant slice of a wider cascaded comparator.

## Interface
Parameters:
- WIDTH, 4, operand width in bits (>= 1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- iData_a  input  WIDTH  operand A, unsigned
- iData_b  input  WIDTH  operand B, unsigned
- iData  input  3  cascade input from less-significant slice: [2]=A>B, [1]=A<B, [0]=A=B
- oData  output  3  registered result, same bit mapping as iData: [2]=A>B, [1]=A<B, [0]=A=B

## Operation
- Unsigned magnitude compare of iData_a vs iData_b over all WIDTH bits. MSB decides first.
- iData_a > iData_b -> next result 3'b100, regardless of iData.
- iData_a < iData_b -> next result 3'b010, regardless of iData.
- iData_a == iData_b -> result taken from the cascade input with priority eq > gt > lt:
  - iData[0]=1 -> 3'b001
  - else iData[2]=1 -> 3'b100
  - else iData[1]=1 -> 3'b010
  - iData=3'b000 -> 3'b001
- This table covers all 8 cascade codes. Illegal multi-hot cascade codes resolve by priority; no error flag.
- After reset, oData is always exactly one-hot. The only non-one-hot value is the reset value 3'b000.
- Chaining: a slice's oData drives the next more-significant slice's iData. Each slice adds its own register latency.

## Timing
- rst high at a rising edge -> oData = 3'b000 on that edge. Inputs are ignored during that edge.
- Reset is synchronous only. Asserting rst between edges has no effect until the next edge.
- Without DATA_COMPARE_INREG_EN:
  - Latency is 1 cycle. Inputs sampled at edge N appear on oData after edge N.
  - First valid result appears on the first edge with rst low.
- With DATA_COMPARE_INREG_EN:
  - Latency is 2 cycles.
  - The input register clears to a_reg=0, b_reg=0, cascade=3'b001 on reset.
  - The first edge after reset therefore outputs 3'b001.
- Throughput is one comparison per cycle. No handshake; the output is continuously updated.
- Reset released mid-stream: the pipeline refills. No stale pre-reset data may reach oData.

## Configuration
- Macro DATA_COMPARE_INREG_EN.
- Defined: an input register stage on iData_a, iData_b and iData precedes the compare logic. Latency is 2 cycles, for timing closure when cascading many slices.
- Undefined: the compare is combinational from the ports into the single oData register. Latency is 1 cycle.
- Function and reset value of oData are identical in both builds; only latency differs.

## Test plan
Default build, WIDTH=4. Check oData one edge after applying the inputs, or two edges with DATA_COMPARE_INREG_EN defined.
- rst=1 for 2 edges with arbitrary inputs -> oData=3'b000; release rst -> first result appears after the stated latency.
- a=4'b1111, b=4'b0000, iData=3'b000 -> oData=3'b100. Repeat with iData=3'b010 -> still 3'b100.
- a=4'b0000, b=4'b1111, iData=3'b000 -> oData=3'b010. Also check MSB dominance: a=4'b0111, b=4'b1000 -> 3'b010.
- a=b=4'b1100 with iData=3'b100 -> 3'b100; iData=3'b010 -> 3'b010; iData=3'b001 -> 3'b001; iData=3'b000 -> 3'b001; iData=3'b111 -> 3'b001; iData=3'b110 -> 3'b100.
- Back-to-back vectors changing every cycle -> each result appears exactly at the stated latency with no skipped or duplicated cycles. Assert rst mid-stream -> 3'b000 on that edge and pipeline flush.
- Exhaustive: all 256 (a, b) pairs × 8 cascade codes compared against a reference model; additionally chain two slices to form an 8-bit compare and check random pairs.
